pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255: maximum memory-wait cycles before a timeout is flagged.
REQ-002 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports id_src1, id_src2  in  4 each  ID-stage source register numbers; id_src1_vld, id_src2_vld  in  1 each  source is actually read.
REQ-005 SHALL have ports exe_dest  in  4, exe_wb_en  in  1, exe_mem_r_en  in  1  EXE-stage destination, writeback enable and load flag.
REQ-006 SHALL have ports mem_dest  in  4, mem_wb_en  in  1; wb_dest  in  4, wb_wb_en  in  1  MEM- and WB-stage destination and writeback enable.
REQ-007 SHALL have ports exe_src1, exe_src2  in  4 each  EXE-stage operand register numbers (forwarding only).
REQ-008 SHALL have ports branch_taken  in  1  EXE-stage branch resolved taken; mem_req  in  1  MEM-stage access active; mem_ready  in  1  memory acknowledge.
REQ-009 SHALL have outputs freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, stall_pipe  out  1 each  pipeline control.
REQ-010 SHALL have outputs fwd_sel_a, fwd_sel_b  out  2 each  EXE operand source select; mem_timeout  out  1  sticky error; stall_cnt  out  16  saturating stall-cycle counter.

Function
REQ-011 SHALL implement a memory-wait FSM with states IDLE and WAIT; IDLE->WAIT when mem_req=1 and mem_ready=0; WAIT->IDLE when mem_ready=1.
REQ-012 SHALL assert stall_pipe combinationally in IDLE when mem_req=1 and mem_ready=0, and in WAIT while mem_ready=0; stall_pipe=1 SHALL also force freeze_pc=1 and freeze_if_id=1.
REQ-013 SHALL count WAIT cycles in an 8-bit counter cleared on entry to WAIT; when it reaches WAIT_LIMIT, mem_timeout SHALL set and stay set until reset; FSM remains in WAIT.
REQ-014 SHALL detect a data hazard when a valid ID source equals exe_dest with exe_wb_en=1, or equals mem_dest with mem_wb_en=1 (non-forwarding mode).
REQ-015 SHALL, on a data hazard with no memory stall, assert freeze_pc=1, freeze_if_id=1 and flush_id_exe=1 (bubble insertion), zero-cycle latency.
REQ-016 SHALL, on branch_taken=1 with no memory stall, assert flush_if_id=1 and flush_id_exe=1 and deassert freeze_pc/freeze_if_id, overriding any data hazard.
REQ-017 SHALL apply priority: memory stall > branch flush > data hazard; a branch_taken held during a stall SHALL take effect in the first non-stalled cycle.
REQ-018 SHALL never assert flush_if_id or flush_id_exe while stall_pipe=1.
REQ-019 SHALL increment stall_cnt by one each cycle any of stall_pipe or hazard-freeze is asserted, saturating at 16'hFFFF.
REQ-020 SHALL treat register 15 as a normal register number for comparison.

Reset
REQ-021 SHALL, while rst=1, hold FSM in IDLE, wait counter 0, stall_cnt 0, mem_timeout 0, and force all outputs to 0.
REQ-022 SHALL, on rst asserted mid-WAIT, abandon the wait immediately; after release, behave as from IDLE.

Configuration
REQ-023 SHALL support macro FORWARDING_EN; when defined, REQ-014 hazard is only a load-use: exe_mem_r_en=1, exe_wb_en=1, valid ID source equals exe_dest.
REQ-024 SHALL, with FORWARDING_EN, set fwd_sel_x=2'b01 if exe_srcx equals mem_dest with mem_wb_en=1, else 2'b10 if equals wb_dest with wb_wb_en=1, else 2'b00 (MEM wins).
REQ-025 SHALL, without FORWARDING_EN, tie fwd_sel_a/fwd_sel_b to 2'b00 and keep the ports.

Structure
REQ-026 SHALL place FSM state enum, fwd_sel encodings (NONE=00, MEM=01, WB=10) and default WAIT_LIMIT in shared package pipe_ctrl_pkg.
REQ-027 SHALL implement the memory-wait FSM, wait counter and timeout in sub-module mem_wait_fsm.

Verification
REQ-028 SHALL cover: id_src1=3 vld, exe_dest=3 exe_wb_en=1 (no macro) -> freeze_pc=freeze_if_id=flush_id_exe=1 same cycle.
REQ-029 SHALL cover: branch_taken=1 with simultaneous hazard -> flush_if_id=flush_id_exe=1, freeze_pc=0.
REQ-030 SHALL cover: mem_req=1, mem_ready=0 for 4 cycles then 1 -> stall_pipe=1 for 4 cycles, stall_cnt=4, FSM back to IDLE.
REQ-031 SHALL cover: WAIT_LIMIT=5, mem_ready held 0 -> mem_timeout=1 after 5 WAIT cycles, remains 1 until rst.
REQ-032 SHALL cover with FORWARDING_EN: exe_src1=2, mem_dest=2 mem_wb_en=1, wb_dest=2 wb_wb_en=1 -> fwd_sel_a=01; load to r4 with id_src2=4 -> one-cycle bubble.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, forwarding encodings and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic {IDLE, WAIT} wait_state_t;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam int DEFAULT_WAIT_LIMIT = 255;
    // The MEM stage holds the younger result, so it wins over WB.
    function automatic logic [1:0] fwd_pick(input logic [3:0] src, input logic [3:0] mem_dest,
                                            input logic mem_wb_en, input logic [3:0] wb_dest,
                                            input logic wb_wb_en);
        return (mem_wb_en && src == mem_dest) ? FWD_MEM :
               (wb_wb_en && src == wb_dest) ? FWD_WB : FWD_NONE;
    endfunction
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: memory-wait state machine with a bounded wait counter and a sticky timeout flag.
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ready,
    output logic stall_pipe,
    output logic mem_timeout
);
    localparam logic [8:0] LIMIT = 9'(WAIT_LIMIT);
    wait_state_t state, state_nxt;
    logic [7:0] wait_cnt;
    always_comb begin
        stall_pipe = !rst && (state == IDLE ? (mem_req && !mem_ready) : !mem_ready);
        state_nxt  = (state == IDLE) ? ((mem_req && !mem_ready) ? WAIT : IDLE)
                                     : (mem_ready ? IDLE : WAIT);
    end
    // The counter idles at zero, so every entry into WAIT starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                wait_cnt <= '0;
            else if (!mem_ready && {1'b0, wait_cnt} < LIMIT)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == WAIT && !mem_ready && ({1'b0, wait_cnt} + 9'd1) >= LIMIT)
                mem_timeout <= 1'b1;
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze control for a 5-stage pipeline.
// Define FORWARDING_EN to restrict hazards to load-use and drive the operand forwarding selects.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_src1_vld,
    input  logic        id_src2_vld,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic [3:0]  wb_dest,
    input  logic        wb_wb_en,
    input  logic [3:0]  exe_src1,
    input  logic [3:0]  exe_src2,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        freeze_pc,
    output logic        freeze_if_id,
    output logic        flush_if_id,
    output logic        flush_id_exe,
    output logic        stall_pipe,
    output logic [1:0]  fwd_sel_a,
    output logic [1:0]  fwd_sel_b,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt
);
    logic hit1, hit2, hazard, branch_go, bubble;
    mem_wait_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .stall_pipe (stall_pipe),
        .mem_timeout(mem_timeout)
    );
`ifdef FORWARDING_EN
    always_comb begin
        hit1      = exe_mem_r_en && exe_wb_en && id_src1 == exe_dest;
        hit2      = exe_mem_r_en && exe_wb_en && id_src2 == exe_dest;
        fwd_sel_a = rst ? FWD_NONE : fwd_pick(exe_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
        fwd_sel_b = rst ? FWD_NONE : fwd_pick(exe_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
    end
    logic unused_ok;
    assign unused_ok = 1'b0;
`else
    always_comb begin
        hit1      = (exe_wb_en && id_src1 == exe_dest) || (mem_wb_en && id_src1 == mem_dest);
        hit2      = (exe_wb_en && id_src2 == exe_dest) || (mem_wb_en && id_src2 == mem_dest);
        fwd_sel_a = FWD_NONE;
        fwd_sel_b = FWD_NONE;
    end
    logic unused_ok;
    assign unused_ok = ^{exe_mem_r_en, exe_src1, exe_src2, wb_dest, wb_wb_en};
`endif
    // Priority: memory stall, then taken branch, then data hazard bubble.
    always_comb begin
        hazard       = (id_src1_vld && hit1) || (id_src2_vld && hit2);
        branch_go    = !rst && !stall_pipe && branch_taken;
        bubble       = !rst && !stall_pipe && !branch_taken && hazard;
        freeze_pc    = stall_pipe || bubble;
        freeze_if_id = stall_pipe || bubble;
        flush_if_id  = branch_go;
        flush_id_exe = branch_go || bubble;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (freeze_pc && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
endmodule
